// File: rtl/shift_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : shift_sequencer_if
//  Description : Bundle of the request, shift-unit and result signals of the
//                shift sequencer.
//                  req_valid/req_ready/req_data/req_op/req_amt : request side
//                  sh_operand1/sh_operand2/sh_result           : shift unit
//                  res_valid/res_ready/result                  : result side
//                  busy                                        : status
//                slave  = sequencer view, master = environment view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface shift_sequencer_if;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_data;
  logic [1:0] req_op;
  logic [7:0] req_amt;
  logic [7:0] sh_operand1;
  logic [7:0] sh_operand2;
  logic [7:0] sh_result;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] result;
  logic       busy;

  modport slave (
    input  req_valid, req_data, req_op, req_amt, sh_result, res_ready,
    output req_ready, sh_operand1, sh_operand2, res_valid, result, busy
  );

  modport master (
    output req_valid, req_data, req_op, req_amt, sh_result, res_ready,
    input  req_ready, sh_operand1, sh_operand2, res_valid, result, busy
  );
endinterface
`default_nettype wire

// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : shift_sequencer
//  Description : Multi-cycle controller around an 8-bit combinational
//                shift/rotate unit. Each request is split into steps of at
//                most STEP_MAX bits, one step per clock, and the result is
//                accumulated and presented with a valid/ready handshake.
//  Ports       : clk   - system clock, rising edge
//                rst_n - asynchronous active-low reset
//                bus   - shift_sequencer_if.slave (request, shift unit,
//                        result handshake and busy status)
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_sequencer #(
  parameter int unsigned STEP_MAX = 7   // 1..7
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  shift_sequencer_if.slave   bus
);

  localparam logic [3:0] STEP_MAX_W = 4'(STEP_MAX);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Step issued for a given remaining amount: min(rem, STEP_MAX).
  function automatic logic [2:0] step_of(input logic [3:0] rem);
    logic [3:0] s;
    s = (rem > STEP_MAX_W) ? STEP_MAX_W : rem;
    return s[2:0];
  endfunction

  state_t     state_q, state_d;
  logic [7:0] acc_q, acc_d;
  logic [3:0] rem_q, rem_d;
  logic [1:0] op_q, op_d;

  // Registered outputs, computed from the next-state values.
  logic       req_ready_q, req_ready_d;
  logic       res_valid_q, res_valid_d;
  logic       busy_q, busy_d;
  logic [7:0] result_q, result_d;
  logic [7:0] sh_op1_q, sh_op1_d;
  logic [7:0] sh_op2_q, sh_op2_d;

  logic [3:0] eff;
  logic [2:0] step_cur;

  always_comb begin
    // Rotates wrap modulo 8; plain shifts saturate at 8, which already
    // clears (or sign-fills) every bit.
    if (bus.req_op == 2'b11) begin
      eff = {1'b0, bus.req_amt[2:0]};
    end else if (bus.req_amt > 8'd8) begin
      eff = 4'd8;
    end else begin
      eff = bus.req_amt[3:0];
    end

    step_cur = step_of(rem_q);

    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    op_d    = op_q;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          acc_d   = bus.req_data;
          op_d    = bus.req_op;
          rem_d   = eff;
          state_d = (eff != 4'd0) ? S_SHIFT : S_DONE;
        end
      end
      S_SHIFT: begin
        acc_d   = bus.sh_result;
        rem_d   = rem_q - {1'b0, step_cur};
        state_d = (rem_d == 4'd0) ? S_DONE : S_SHIFT;
      end
      S_DONE: begin
        if (bus.res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    req_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    res_valid_d = (state_d == S_DONE);
    // Result is frozen once in DONE; the request inputs cannot disturb it
    // because acc only loads in IDLE and SHIFT.
    result_d    = (state_d == S_DONE) ? acc_d : result_q;
    sh_op1_d    = (state_d == S_SHIFT) ? acc_d : 8'h00;
    sh_op2_d    = (state_d == S_SHIFT) ? {op_d, 3'b000, step_of(rem_d)} : 8'h00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      acc_q       <= 8'h00;
      rem_q       <= 4'd0;
      op_q        <= 2'b00;
      req_ready_q <= 1'b1;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      result_q    <= 8'h00;
      sh_op1_q    <= 8'h00;
      sh_op2_q    <= 8'h00;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      rem_q       <= rem_d;
      op_q        <= op_d;
      req_ready_q <= req_ready_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
      result_q    <= result_d;
      sh_op1_q    <= sh_op1_d;
      sh_op2_q    <= sh_op2_d;
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.busy        = busy_q;
  assign bus.result      = result_q;
  assign bus.sh_operand1 = sh_op1_q;
  assign bus.sh_operand2 = sh_op2_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_sequencer
//  Description : Directed and random testbench for shift_sequencer with a
//                behavioural model of the 8-bit shift/rotate unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_sequencer;

  logic clk;
  logic rst_n;
  int   tests;
  int   errors;
  logic [7:0] op2_trace [4];

  shift_sequencer_if bus();

  shift_sequencer #(.STEP_MAX(7)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational shift unit: op in [7:6], amount in [2:0].
  always_comb begin
    logic [15:0] dbl;
    logic [2:0]  a;
    a   = bus.sh_operand2[2:0];
    dbl = {bus.sh_operand1, bus.sh_operand1} >> a;
    case (bus.sh_operand2[7:6])
      2'b00:   bus.sh_result = bus.sh_operand1 << a;
      2'b01:   bus.sh_result = bus.sh_operand1 >> a;
      2'b10:   bus.sh_result = 8'($signed(bus.sh_operand1) >>> a);
      default: bus.sh_result = dbl[7:0];
    endcase
  end

  // Reference result for the whole request.
  function automatic logic [7:0] ref_shift(input logic [7:0] d, input logic [1:0] op,
                                           input logic [7:0] amt);
    logic [15:0] dbl;
    int n;
    n   = amt % 8;
    dbl = {d, d} >> n;
    case (op)
      2'b00:   return (amt >= 8) ? 8'h00 : d << amt;
      2'b01:   return (amt >= 8) ? 8'h00 : d >> amt;
      2'b10:   return (amt >= 8) ? {8{d[7]}} : 8'($signed(d) >>> amt);
      default: return dbl[7:0];
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input logic [7:0] amt);
    int e;
    e = (op == 2'b11) ? (amt % 8) : ((amt > 8) ? 8 : int'(amt));
    return (e == 0) ? 1 : 1 + (e + 6) / 7;
  endfunction

  // Offer a request, wait for acceptance, then count negedges until res_valid.
  // Called and returns at a negedge; res_ready is left low.
  task automatic run_req(input logic [7:0] d, input logic [1:0] op, input logic [7:0] amt,
                         output logic [7:0] res, output int lat);
    int guard;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_data  = d;
    bus.req_op    = op;
    bus.req_amt   = amt;
    guard = 0;
    while (!bus.req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = 0;
    for (int i = 0; i < 4; i++) op2_trace[i] = 8'hxx;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i < 4) op2_trace[i] = bus.sh_operand2;
      if (bus.res_valid) begin
        lat = i + 1;
        break;
      end
    end
    res = bus.result;
  endtask

  task automatic release_res();
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1 bus.res_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic seen;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({bus.req_ready, bus.res_valid, bus.busy} !== 3'b100 || bus.result !== 8'h00 ||
        bus.sh_operand1 !== 8'h00 || bus.sh_operand2 !== 8'h00) begin
      errors++;
      $display("FAIL reset_defaults: rdy/vld/busy=%b res=%h op1=%h op2=%h, want 100 00 00 00",
               {bus.req_ready, bus.res_valid, bus.busy}, bus.result, bus.sh_operand1, bus.sh_operand2);
    end
    rst_n = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_data = 8'h81; bus.req_op = 2'b00; bus.req_amt = 8'd8;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.busy !== 1'b1 || bus.sh_operand1 !== 8'h81 || bus.sh_operand2 !== 8'h07) begin
      errors++;
      $display("FAIL reset_pre_shift: busy=%b op1=%h op2=%h, want 1 81 07",
               bus.busy, bus.sh_operand1, bus.sh_operand2);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({bus.req_ready, bus.res_valid, bus.busy} !== 3'b100 || bus.result !== 8'h00 ||
        bus.sh_operand1 !== 8'h00 || bus.sh_operand2 !== 8'h00) begin
      errors++;
      $display("FAIL reset_async_abort: rdy/vld/busy=%b res=%h op1=%h op2=%h, want 100 00 00 00",
               {bus.req_ready, bus.res_valid, bus.busy}, bus.result, bus.sh_operand1, bus.sh_operand2);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.res_valid) seen = 1'b1;
    end
    tests++;
    if (seen !== 1'b0 || bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_no_result: res_valid_seen=%b req_ready=%b, want 0 1", seen, bus.req_ready);
    end
  endtask

  task automatic test_sll();
    logic [7:0] r; int l;
    run_req(8'h81, 2'b00, 8'd3, r, l);
    tests++;
    if (r !== 8'h08 || l != 2) begin
      errors++;
      $display("FAIL sll_81_3: result=%h lat=%0d, want 08 2", r, l);
    end
    tests++;
    if (op2_trace[0] !== 8'h03 || op2_trace[1] !== 8'h00) begin
      errors++;
      $display("FAIL sll_op2_pulse: op2=%h,%h want 03,00", op2_trace[0], op2_trace[1]);
    end
    release_res();
  endtask

  task automatic test_saturate();
    logic [7:0] r; int l;
    run_req(8'h90, 2'b10, 8'd200, r, l);
    tests++;
    if (r !== 8'hFF || l != 3) begin
      errors++;
      $display("FAIL sra_90_200: result=%h lat=%0d, want ff 3", r, l);
    end
    tests++;
    if (op2_trace[0] !== 8'h87 || op2_trace[1] !== 8'h81) begin
      errors++;
      $display("FAIL sra_steps: op2=%h,%h want 87,81", op2_trace[0], op2_trace[1]);
    end
    release_res();
    run_req(8'h90, 2'b01, 8'd9, r, l);
    tests++;
    if (r !== 8'h00 || l != 3) begin
      errors++;
      $display("FAIL srl_90_9: result=%h lat=%0d, want 00 3", r, l);
    end
    release_res();
  endtask

  task automatic test_ror();
    logic [7:0] r; int l;
    run_req(8'hA5, 2'b11, 8'h0B, r, l);
    tests++;
    if (r !== 8'hB4 || l != 2 || op2_trace[0] !== 8'hC3) begin
      errors++;
      $display("FAIL ror_a5_0b: result=%h lat=%0d op2=%h, want b4 2 c3", r, l, op2_trace[0]);
    end
    release_res();
    run_req(8'hA5, 2'b11, 8'h08, r, l);
    tests++;
    if (r !== 8'hA5 || l != 1) begin
      errors++;
      $display("FAIL ror_a5_8: result=%h lat=%0d, want a5 1", r, l);
    end
    release_res();
    run_req(8'h5C, 2'b00, 8'h00, r, l);
    tests++;
    if (r !== 8'h5C || l != 1) begin
      errors++;
      $display("FAIL sll_5c_0: result=%h lat=%0d, want 5c 1", r, l);
    end
    release_res();
  endtask

  task automatic test_backpressure();
    logic [7:0] r; int l; logic bad;
    run_req(8'h0F, 2'b00, 8'd1, r, l);
    tests++;
    if (r !== 8'h1E || l != 2) begin
      errors++;
      $display("FAIL bp_first: result=%h lat=%0d, want 1e 2", r, l);
    end
    bus.req_valid = 1'b1; bus.req_data = 8'h3C; bus.req_op = 2'b00; bus.req_amt = 8'd2;
    bad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (bus.res_valid !== 1'b1 || bus.result !== 8'h1E || bus.req_ready !== 1'b0 ||
          bus.busy !== 1'b1) bad = 1'b1;
    end
    tests++;
    if (bad !== 1'b0) begin
      errors++;
      $display("FAIL bp_hold: unstable during stall, last vld=%b res=%h rdy=%b, want 1 1e 0",
               bus.res_valid, bus.result, bus.req_ready);
    end
    release_res();
    @(negedge clk);
    tests++;
    if (bus.req_ready !== 1'b1 || bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_turnaround: rdy=%b vld=%b busy=%b, want 1 0 0",
               bus.req_ready, bus.res_valid, bus.busy);
    end
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.busy !== 1'b1 || bus.sh_operand1 !== 8'h3C || bus.sh_operand2 !== 8'h02) begin
      errors++;
      $display("FAIL bp_accept: busy=%b op1=%h op2=%h, want 1 3c 02",
               bus.busy, bus.sh_operand1, bus.sh_operand2);
    end
    @(negedge clk);
    tests++;
    if (bus.res_valid !== 1'b1 || bus.result !== 8'hF0) begin
      errors++;
      $display("FAIL bp_second: vld=%b result=%h, want 1 f0", bus.res_valid, bus.result);
    end
    release_res();
  endtask

  task automatic test_back_to_back();
    logic [7:0] d, amt, r; logic [1:0] op; int l; logic bad;
    for (int n = 0; n < 1000; n++) begin
      d   = 8'($urandom);
      op  = 2'($urandom);
      amt = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 10));
      run_req(d, op, amt, r, l);
      tests++;
      if (r !== ref_shift(d, op, amt) || l != ref_lat(op, amt)) begin
        errors++;
        $display("FAIL rand_%0d d=%h op=%0d amt=%0d: result=%h lat=%0d, want %h %0d",
                 n, d, op, amt, r, l, ref_shift(d, op, amt), ref_lat(op, amt));
      end
      bad = 1'b0;
      repeat ($urandom_range(0, 2)) begin
        bus.req_data = 8'($urandom);
        @(negedge clk);
        if (bus.res_valid !== 1'b1 || bus.result !== r) bad = 1'b1;
      end
      tests++;
      if (bad !== 1'b0) begin
        errors++;
        $display("FAIL rand_stable_%0d: result changed while stalled, now %h want %h",
                 n, bus.result, r);
      end
      release_res();
    end
  endtask

  initial begin
    tests = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_data  = 8'h00;
    bus.req_op    = 2'b00;
    bus.req_amt   = 8'h00;
    bus.res_ready = 1'b0;
    test_reset();
    test_sll();
    test_saturate();
    test_ror();
    test_backpressure();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
`default_nettype wire
